// File: rtl/vga_pkg.sv
// Shared raster constants and helpers for the VGA timing slice.
// 640x480@60 defaults, position width and sync-window decode.
package vga_pkg;

    localparam int unsigned XY_W = 12;

    localparam int unsigned DEF_H_ACTIVE     = 640;
    localparam int unsigned DEF_H_FP         = 16;
    localparam int unsigned DEF_H_SYNC       = 96;
    localparam int unsigned DEF_H_BP         = 48;
    localparam int unsigned DEF_V_ACTIVE     = 480;
    localparam int unsigned DEF_V_FP         = 10;
    localparam int unsigned DEF_V_SYNC       = 2;
    localparam int unsigned DEF_V_BP         = 33;
    localparam int unsigned DEF_BLINK_FRAMES = 30;

    function automatic int unsigned vga_total(input int unsigned active, input int unsigned fp,
                                              input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    // True when pos lies in [lo, lo+width)
    function automatic logic in_window(input logic [XY_W-1:0] pos, input int unsigned lo,
                                       input int unsigned width);
        return (32'(pos) >= lo) && (32'(pos) < lo + width);
    endfunction

endpackage

// File: rtl/vga_wrap_counter.sv
// Wrapping position counter 0..MAX with enable, terminal-count flag
// and asynchronous active-low clear.
module vga_wrap_counter
    import vga_pkg::*;
#(
    parameter int unsigned MAX = 799
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            en,
    output logic [XY_W-1:0] count,
    output logic            tc
);

    assign tc = (count == XY_W'(MAX));

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            count <= '0;
        end else if (en) begin
            count <= tc ? '0 : count + XY_W'(1);
        end
    end

endmodule

// File: rtl/vga_timing.sv
// Raster timing generator: registered, mutually aligned sync/position/valid,
// frame-start strobe and blink phase. Optional VGA_TIMING_LINE_IRQ_EN adds line_cmp/line_hit.
module vga_timing
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE     = DEF_H_ACTIVE,
    parameter int unsigned H_FP         = DEF_H_FP,
    parameter int unsigned H_SYNC       = DEF_H_SYNC,
    parameter int unsigned H_BP         = DEF_H_BP,
    parameter int unsigned V_ACTIVE     = DEF_V_ACTIVE,
    parameter int unsigned V_FP         = DEF_V_FP,
    parameter int unsigned V_SYNC       = DEF_V_SYNC,
    parameter int unsigned V_BP         = DEF_V_BP,
    parameter logic        H_POL        = 1'b0,
    parameter logic        V_POL        = 1'b0,
    parameter int unsigned BLINK_FRAMES = DEF_BLINK_FRAMES
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            en,
`ifdef VGA_TIMING_LINE_IRQ_EN
    input  logic [XY_W-1:0] line_cmp,
    output logic            line_hit,
`endif
    output logic            xsync,
    output logic            ysync,
    output logic [XY_W-1:0] xpos,
    output logic [XY_W-1:0] ypos,
    output logic            valid,
    output logic            frame_start,
    output logic            blink
);

    localparam int unsigned H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned FW      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [XY_W-1:0] hcnt;
    logic [XY_W-1:0] vcnt;
    logic            h_tc;
    logic            v_tc;
    logic            v_en;
    logic [FW-1:0]   fcnt;

    assign v_en = en & h_tc;

    vga_wrap_counter #(.MAX(H_TOTAL - 1)) u_hcnt (
        .clk   (clk),
        .clr   (clr),
        .en    (en),
        .count (hcnt),
        .tc    (h_tc)
    );

    vga_wrap_counter #(.MAX(V_TOTAL - 1)) u_vcnt (
        .clk   (clk),
        .clr   (clr),
        .en    (v_en),
        .count (vcnt),
        .tc    (v_tc)
    );

    // Outputs sample the pre-advance counter values, so everything stays pixel-aligned
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            xpos        <= '0;
            ypos        <= '0;
            valid       <= 1'b0;
            xsync       <= ~H_POL;
            ysync       <= ~V_POL;
            frame_start <= 1'b0;
        end else if (en) begin
            xpos        <= hcnt;
            ypos        <= vcnt;
            valid       <= (32'(hcnt) < H_ACTIVE) && (32'(vcnt) < V_ACTIVE);
            xsync       <= in_window(hcnt, H_ACTIVE + H_FP, H_SYNC) ? H_POL : ~H_POL;
            ysync       <= in_window(vcnt, V_ACTIVE + V_FP, V_SYNC) ? V_POL : ~V_POL;
            frame_start <= (hcnt == '0) && (vcnt == '0);
        end else begin
            frame_start <= 1'b0;
        end
    end

    // Comparing against BLINK_FRAMES-1 avoids overflowing FW when BLINK_FRAMES is a power of two
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            fcnt  <= '0;
            blink <= 1'b0;
        end else if (en && h_tc && v_tc) begin
            if (fcnt == FW'(BLINK_FRAMES - 1)) begin
                fcnt  <= '0;
                blink <= ~blink;
            end else begin
                fcnt <= fcnt + FW'(1);
            end
        end
    end

`ifdef VGA_TIMING_LINE_IRQ_EN
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            line_hit <= 1'b0;
        end else if (en) begin
            line_hit <= (hcnt == '0) && (vcnt == line_cmp);
        end else begin
            line_hit <= 1'b0;
        end
    end
`endif

endmodule

// File: doc/vga_timing.md
Name: vga_timing

Overview:
- Raster timing generator that drives the pixel-position/sync pipeline consumed by the text-mode VGA memory.
- Produces xsync, ysync, xpos, ypos and valid, all registered and mutually aligned.
- Adds a frame-start strobe and a blink phase for character blink attributes.
- Sits between the system clock domain (with a pixel-rate enable) and the text memory/renderer chain.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
H_POL, 0, active level of xsync
V_POL, 0, active level of ysync
BLINK_FRAMES, 30, frames per blink half-period (>=1)

Ports:
clk  in  1  system clock; single clock domain
clr  in  1  asynchronous active-low reset
en  in  1  pixel tick enable; the state advances only on clk edges with en=1
xsync  out  1  horizontal sync, level H_POL when asserted
ysync  out  1  vertical sync, level V_POL when asserted
xpos  out  12  current pixel column, 0..H_TOTAL-1
ypos  out  12  current line, 0..V_TOTAL-1
valid  out  1  1 when xpos<H_ACTIVE and ypos<V_ACTIVE
frame_start  out  1  one-clk pulse when (xpos,ypos) becomes (0,0)
blink  out  1  blink phase; toggles every BLINK_FRAMES frames

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525). Both must be <= 4096.
- Internal counters hcnt and vcnt are 12 bit.
  - hcnt wraps H_TOTAL-1 -> 0.
  - vcnt increments only on the hcnt wrap, and wraps V_TOTAL-1 -> 0.
- Output registers load on each clk edge with en=1, from the counter values before that edge advances them.
  - xpos/ypos therefore lag the counters by one tick.
  - All outputs describe the same pixel; no output is skewed relative to another.
- xsync = H_POL when H_ACTIVE+H_FP <= xpos < H_ACTIVE+H_FP+H_SYNC, else ~H_POL. ysync uses the same rule on ypos with the V_* parameters.
- With en=0, all outputs and counters hold. frame_start is forced to 0 on any clk edge where en=0, so the pulse lasts exactly one clk.
- Reset (clr=0, asynchronous, any time including mid-frame):
  - hcnt=vcnt=0, xpos=ypos=0, valid=0, xsync=~H_POL, ysync=~V_POL, frame_start=0, blink=0, frame counter=0.
  - After release, the first en edge outputs xpos=0, ypos=0, valid=1, frame_start=1.
- Blink:
  - The frame counter (ceil(log2(BLINK_FRAMES)) bits, minimum 1) increments on each en edge where the counters are at (H_TOTAL-1, V_TOTAL-1).
  - When the increment would reach BLINK_FRAMES, the counter clears and blink toggles on the same edge.
  - BLINK_FRAMES=1 toggles blink every frame.
- No combinational path from any input to any output.

Optional Feature:
- Macro VGA_TIMING_LINE_IRQ_EN. When defined, adds:
  - input line_cmp[11:0];
  - output line_hit, a one-clk pulse on the edge where the outputs become (xpos=0, ypos=line_cmp).
- line_cmp >= V_TOTAL never hits. line_hit resets to 0.
- When undefined, both ports are absent and no compare logic is built.

Decomposition:
- Shared package vga_pkg:
  - 640x480@60 timing constants;
  - position width XY_W=12;
  - a function computing H_TOTAL/V_TOTAL;
  - sync-window decode helper.
- One sub-module, vga_wrap_counter: a 12-bit counter with enable, parameter MAX, a terminal-count output, and asynchronous active-low clear. It is instantiated for hcnt and vcnt; vcnt's enable is en AND the hcnt terminal count.

Test Plan:
- Reset then en=1 constantly → first edge: xpos=0, ypos=0, valid=1, frame_start=1. The next 799 edges step xpos 1..799 with ypos=0; valid=0 once xpos reaches 640.
- Line 0 sweep → xsync=0 exactly for xpos 656..751 (96 ticks), 1 elsewhere. ysync=0 exactly for ypos 490..491.
- Run past (799,524) → next output (0,0) with frame_start=1. Exactly one frame_start pulse per 420000 en ticks.
- en toggling 1,0,0,0 (pixel rate = clk/4) → outputs change only on en edges. frame_start is high for 1 clk, not 4.
- Run 30 full frames from reset → blink goes 0→1 at the edge leaving (799,524) of frame 29, and back to 0 after frame 59.
- Assert clr at xpos=300, ypos=200 → all outputs reset asynchronously without waiting for clk. After release, restart at (0,0). With VGA_TIMING_LINE_IRQ_EN and line_cmp=100: line_hit pulses once per frame at (0,100).
